// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller.
// Contents: light encodings, phase state codes, default timer width and
// helpers that decode a phase into the two light-head values.
package traffic_pkg;

  localparam int unsigned TW_DEFAULT = 6;

  // One-hot {R,Y,G}
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    MainGreen  = 3'd0,
    MainYellow = 3'd1,
    AllRed1    = 3'd2,
    SideGreen  = 3'd3,
    SideYellow = 3'd4,
    AllRed2    = 3'd5
  } state_e;

  function automatic logic [2:0] main_light_of(input state_e st);
    case (st)
      MainGreen:  main_light_of = LIGHT_GREEN;
      MainYellow: main_light_of = LIGHT_YELLOW;
      default:    main_light_of = LIGHT_RED;
    endcase
  endfunction

  function automatic logic [2:0] side_light_of(input state_e st);
    case (st)
      SideGreen:  side_light_of = LIGHT_GREEN;
      SideYellow: side_light_of = LIGHT_YELLOW;
      default:    side_light_of = LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/intersection_controller_if.sv
// Bundle of configuration, request and light signals of the intersection
// controller.
//   cfg_main_green/cfg_side_green/cfg_yellow/cfg_allred : phase durations D
//   side_req/ped_req       : vehicle detect / pedestrian button
//   main_light/side_light  : one-hot {R,Y,G} heads
//   ped_walk               : walk indication for crossing the main road
//   phase                  : current state code (debug)
// master drives cfg/requests, slave (the controller) drives the outputs.
interface intersection_controller_if #(
  parameter int unsigned TW = 6
);
  logic [TW-1:0] cfg_main_green;
  logic [TW-1:0] cfg_side_green;
  logic [TW-1:0] cfg_yellow;
  logic [TW-1:0] cfg_allred;
  logic          side_req;
  logic          ped_req;
  logic [2:0]    main_light;
  logic [2:0]    side_light;
  logic          ped_walk;
  logic [2:0]    phase;

  modport master (
    output cfg_main_green, cfg_side_green, cfg_yellow, cfg_allred, side_req, ped_req,
    input  main_light, side_light, ped_walk, phase
  );

  modport slave (
    input  cfg_main_green, cfg_side_green, cfg_yellow, cfg_allred, side_req, ped_req,
    output main_light, side_light, ped_walk, phase
  );
endinterface

// File: rtl/intersection_controller_phase_timer.sv
// Phase duration down-counter.
//   clk, reset      : clock, asynchronous active-low reset (count -> 0)
//   i_load          : load i_load_val this edge (phase entry)
//   i_load_val      : duration value D; phase lasts D+1 cycles
//   i_hold_at_zero  : stay at zero instead of wrapping
//   o_zero          : count is zero, phase may exit this edge
module phase_timer #(
  parameter int unsigned TW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_hold_at_zero,
  output logic          o_zero
);

  logic [TW-1:0] r_cnt;
  logic          w_zero;

  assign w_zero = (r_cnt == '0);
  assign o_zero = w_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!(w_zero && i_hold_at_zero)) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

endmodule

// File: rtl/intersection_controller.sv
// Two-head intersection sequencer with pedestrian walk.
// Main road rests on green; a pending side or pedestrian request runs one
// full cycle MG -> MY -> AR1 -> SG -> SY -> AR2 -> MG.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : intersection_controller_if.slave (cfg, requests, lights, walk, phase)
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int unsigned TW = TW_DEFAULT
) (
  input logic                      clk,
  input logic                      reset,
  intersection_controller_if.slave bus
);

  state_e        r_state;
  state_e        w_state_d;
  logic          r_side_pend;
  logic          r_ped_pend;
  logic          r_ped_walk;
  logic [2:0]    r_main_light;
  logic [2:0]    r_side_light;

  logic          w_zero;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_side_in;
  logic          w_ped_in;
  logic          w_enter_sg;
  logic          w_side_pend_d;
  logic          w_ped_pend_d;
  logic          w_ped_walk_d;

  phase_timer #(
    .TW (TW)
  ) u_timer (
    .clk            (clk),
    .reset          (reset),
    .i_load         (w_load),
    .i_load_val     (w_load_val),
    .i_hold_at_zero (r_state == MainGreen),
    .o_zero         (w_zero)
  );

  // Request qualification: side ignored throughout SG, pedestrian only while walk is shown.
  assign w_side_in = bus.side_req && (r_state != SideGreen);
  assign w_ped_in  = bus.ped_req && !((r_state == SideGreen) && r_ped_walk);

  always_comb begin
    w_state_d  = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      MainGreen: begin
        if (w_zero && (r_side_pend || r_ped_pend)) begin
          w_state_d  = MainYellow;
          w_load     = 1'b1;
          w_load_val = bus.cfg_yellow;
        end
      end
      MainYellow: begin
        if (w_zero) begin
          w_state_d  = AllRed1;
          w_load     = 1'b1;
          w_load_val = bus.cfg_allred;
        end
      end
      AllRed1: begin
        if (w_zero) begin
          w_state_d  = SideGreen;
          w_load     = 1'b1;
          w_load_val = bus.cfg_side_green;
        end
      end
      SideGreen: begin
        if (w_zero) begin
          w_state_d  = SideYellow;
          w_load     = 1'b1;
          w_load_val = bus.cfg_yellow;
        end
      end
      SideYellow: begin
        if (w_zero) begin
          w_state_d  = AllRed2;
          w_load     = 1'b1;
          w_load_val = bus.cfg_allred;
        end
      end
      AllRed2: begin
        if (w_zero) begin
          w_state_d  = MainGreen;
          w_load     = 1'b1;
          w_load_val = bus.cfg_main_green;
        end
      end
      default: begin
        // Corrupted code: park in clearance with an expired timer
        w_state_d  = AllRed2;
        w_load     = 1'b1;
        w_load_val = '0;
      end
    endcase
  end

  assign w_enter_sg = (w_state_d == SideGreen) && (r_state != SideGreen);

  always_comb begin
    w_side_pend_d = r_side_pend || w_side_in;
    w_ped_pend_d  = r_ped_pend || w_ped_in;
    w_ped_walk_d  = 1'b0;
    if (w_enter_sg) begin
      // Clear wins over a same-edge set; that request is served by this cycle
      w_side_pend_d = 1'b0;
      w_ped_pend_d  = 1'b0;
      w_ped_walk_d  = r_ped_pend || w_ped_in;
    end else if (w_state_d == SideGreen) begin
      w_ped_walk_d  = r_ped_walk;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= AllRed2;
      r_side_pend  <= 1'b0;
      r_ped_pend   <= 1'b0;
      r_ped_walk   <= 1'b0;
      r_main_light <= LIGHT_RED;
      r_side_light <= LIGHT_RED;
    end else begin
      r_state      <= w_state_d;
      r_side_pend  <= w_side_pend_d;
      r_ped_pend   <= w_ped_pend_d;
      r_ped_walk   <= w_ped_walk_d;
      // Lights registered from next state so they switch with the state, glitch-free
      r_main_light <= main_light_of(w_state_d);
      r_side_light <= side_light_of(w_state_d);
    end
  end

  assign bus.main_light = r_main_light;
  assign bus.side_light = r_side_light;
  assign bus.ped_walk   = r_ped_walk;
  assign bus.phase      = r_state;

endmodule

// File: doc/intersection_controller.md
Name: intersection_controller

Overview:
- Sequences two traffic-light heads (main road, side road) at one intersection, plus a pedestrian walk signal for crossing the main road.
- Main road rests on green. Side-road vehicle or pedestrian requests trigger a full cycle through yellow and all-red clearance, then side green, then back to main green.
- Sits above the single-head light sequencers and owns phase timing and request arbitration.

Parameters:
- TW, 6, width of every duration config field and of the phase timer.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cfg_main_green  in  TW  minimum main-green duration value D.
- cfg_side_green  in  TW  side-green duration value D.
- cfg_yellow  in  TW  yellow duration value D (used for both heads).
- cfg_allred  in  TW  all-red clearance duration value D.
- side_req  in  1  side-road vehicle detect (level or pulse).
- ped_req  in  1  pedestrian push-button (level or pulse).
- main_light  out  3  one-hot {R,Y,G}: RED=100, YELLOW=010, GREEN=001.
- side_light  out  3  same encoding as main_light.
- ped_walk  out  1  walk indication for crossing the main road.
- phase  out  3  current state code, for debug.

Behaviour:
- States and encoding: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_1=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALL_RED_2=5. Codes 6 and 7 are illegal and go to ALL_RED_2 with timer=0.
- Phase timing: on entry to a state, the timer loads that state's cfg value D. It decrements each cycle. The state exits on the edge where timer==0, so the state lasts D+1 cycles; D=0 gives a 1-cycle state.
- Config sampling: each cfg value is sampled only at state entry. Changes mid-state have no effect until the next entry.
- Transition order: MAIN_GREEN -> MAIN_YELLOW -> ALL_RED_1 -> SIDE_GREEN -> SIDE_YELLOW -> ALL_RED_2 -> MAIN_GREEN.
- MAIN_GREEN exit rule: exits only when timer==0 AND (side_pend|ped_pend). Once timer reaches 0 it holds at 0 until a request is pending. With no requests, main green holds indefinitely.
- Request latches (side_pend, ped_pend):
  - Set on any cycle the corresponding request is high.
  - Cleared on the edge that enters SIDE_GREEN; if set and clear fall on the same edge, clear wins (request counts as served).
  - side_req is ignored while in SIDE_GREEN.
  - ped_req is ignored while in SIDE_GREEN with ped_walk=1. Otherwise it latches and is served next cycle.
- Request latency: a request sampled at edge E sets its latch at E. If minimum main green has elapsed, MAIN_YELLOW is entered at edge E+1.
- ped_walk:
  - Registered; set on the edge entering SIDE_GREEN if ped_pend=1 at that edge.
  - Cleared on the edge leaving SIDE_GREEN.
  - High for exactly cfg_side_green+1 cycles and never outside SIDE_GREEN.
- Light decode from state (register-driven, glitch-free):
  - main_light: GREEN in MAIN_GREEN, YELLOW in MAIN_YELLOW, RED otherwise.
  - side_light: GREEN in SIDE_GREEN, YELLOW in SIDE_YELLOW, RED otherwise.
  - Invariant: the two heads are never simultaneously non-RED.
- Reset:
  - Values: state=ALL_RED_2, timer=0, side_pend=ped_pend=0, ped_walk=0, main_light=side_light=100, phase=5.
  - After reset deasserts, the first edge enters MAIN_GREEN.
  - Asserting reset mid-operation forces these values immediately (asynchronously).

Decomposition:
- Package traffic_pkg holds:
  - light encodings RED/YELLOW/GREEN (3-bit);
  - state codes for the six states;
  - TW default.
- One sub-module, phase_timer:
  - Inputs: load, load value, hold_at_zero.
  - Output: zero flag.
  - Down-counter of width TW.

Test Plan:
1. Reset low 3 cycles, release; cfg main=3, side=4, yellow=2, allred=1; no requests for 50 cycles -> both RED for 1 cycle, then main_light=001 held for all 50 cycles, ped_walk=0.
2. side_req pulsed 1 cycle, 20 cycles after MAIN_GREEN entry -> MAIN_YELLOW next edge, then MAIN_YELLOW 3 cycles, ALL_RED_1 2, SIDE_GREEN 5, SIDE_YELLOW 3, ALL_RED_2 2, then MAIN_GREEN; ped_walk stays 0.
3. side_req high on first MAIN_GREEN cycle with cfg_main_green=3 -> MAIN_GREEN lasts exactly 4 cycles before MAIN_YELLOW.
4. ped_req pulse only -> full cycle runs; ped_walk=1 for exactly 5 cycles, coincident with SIDE_GREEN. A second ped_req during that window produces no extra cycle.
5. Reset asserted mid-SIDE_GREEN with ped_walk=1 -> same cycle: both lights 100, ped_walk=0, phase=5; latches cleared (no side cycle after release without a new request).
6. cfg_yellow changed 2->0 mid-MAIN_YELLOW -> current yellow still 3 cycles, next SIDE_YELLOW 1 cycle. All cfg=0 with side_req held high -> each state lasts 1 cycle, main/side never both non-RED.
